// File: rtl/dll_loop_ctrl.sv
// Time-multiplexed DLL controller: one shared early-minus-late discriminator and
// loop-gain stage serving NCH channels. Optional lock detection via DLL_CTRL_LOCK_EN.
module dll_loop_ctrl #(
  parameter int NCH      = 4,
  parameter int PW       = 29,
  parameter int SHIFT    = 6,
  parameter int RATEW    = 32,
  parameter int LOCK_THR = 16,
  parameter int LOCK_CNT = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NCH-1:0]          req_i,
  input  logic [NCH*PW-1:0]       p_e_i,
  input  logic [NCH*PW-1:0]       p_l_i,
  input  logic [NCH-1:0]          ch_clr_i,
  output logic [NCH-1:0]          gnt_o,
  output logic                    busy_o,
  output logic                    upd_valid_o,
  output logic [$clog2(NCH)-1:0]  upd_ch_o,
  output logic signed [RATEW-1:0] upd_rate_o,
  output logic [NCH-1:0]          lock_o
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, DISC, UPDATE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           ptr_q, ch_q, pick_idx;
  logic                    pick_found;
  logic [PW-1:0]           pe_q, pl_q;
  logic signed [PW:0]      err_d, err_q, scaled;
  logic signed [RATEW-1:0] rate_q [NCH];
  logic signed [RATEW:0]   sum;
  logic signed [RATEW-1:0] rate_sat;
  logic [NCH-1:0]          gnt_q;
  logic                    upd_valid_q;
  logic [CW-1:0]           upd_ch_q;
  logic signed [RATEW-1:0] upd_rate_q;

  // Round-robin search starting just above the last granted channel.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!pick_found && req_i[CW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = DISC;
      DISC:    state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Unsigned powers extended by one bit so the difference never overflows.
  assign err_d  = $signed({1'b0, pe_q}) - $signed({1'b0, pl_q});
  assign scaled = err_q >>> SHIFT;
  assign sum    = {rate_q[ch_q][RATEW-1], rate_q[ch_q]} + {{(RATEW-PW){scaled[PW]}}, scaled};

  always_comb begin
    rate_sat = sum[RATEW-1:0];
    if (sum[RATEW] != sum[RATEW-1])
      rate_sat = sum[RATEW] ? {1'b1, {(RATEW-1){1'b0}}} : {1'b0, {(RATEW-1){1'b1}}};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= CW'(NCH - 1);
      ch_q        <= '0;
      pe_q        <= '0;
      pl_q        <= '0;
      err_q       <= '0;
      gnt_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
      upd_rate_q  <= '0;
      for (int i = 0; i < NCH; i++) rate_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= '0;
      upd_valid_q <= 1'b0;
      if (state_q == IDLE && pick_found) begin
        gnt_q <= {{(NCH-1){1'b0}}, 1'b1} << pick_idx;
        ptr_q <= pick_idx;
        ch_q  <= pick_idx;
        pe_q  <= p_e_i[pick_idx*PW +: PW];
        pl_q  <= p_l_i[pick_idx*PW +: PW];
      end
      if (state_q == DISC) err_q <= err_d;
      if (state_q == UPDATE) begin
        rate_q[ch_q] <= rate_sat;
        upd_valid_q  <= 1'b1;
        upd_ch_q     <= ch_q;
        upd_rate_q   <= ch_clr_i[ch_q] ? '0 : rate_sat;
      end
      // A clear on the same edge as that channel's update takes priority.
      for (int i = 0; i < NCH; i++)
        if (ch_clr_i[i]) rate_q[i] <= '0;
    end
  end

`ifdef DLL_CTRL_LOCK_EN
  localparam int CNTW = $clog2(LOCK_CNT + 1);
  localparam logic [PW:0]     LOCK_THR_V = (PW+1)'(LOCK_THR);
  localparam logic [CNTW-1:0] LOCK_CNT_V = CNTW'(LOCK_CNT);

  logic [CNTW-1:0] cnt_q [NCH];
  logic [CNTW-1:0] cnt_nxt;
  logic [PW:0]     err_mag;
  logic [NCH-1:0]  lock_q;

  assign err_mag = err_q[PW] ? -err_q : err_q;

  always_comb begin
    cnt_nxt = '0;
    if (err_mag <= LOCK_THR_V)
      cnt_nxt = (cnt_q[ch_q] == LOCK_CNT_V) ? cnt_q[ch_q] : cnt_q[ch_q] + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lock_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_clr_i[i]) begin
          cnt_q[i]  <= '0;
          lock_q[i] <= 1'b0;
        end else if (state_q == UPDATE && ch_q == CW'(i)) begin
          cnt_q[i]  <= cnt_nxt;
          lock_q[i] <= (cnt_nxt == LOCK_CNT_V);
        end
      end
    end
  end

  assign lock_o = lock_q;
`else
  assign lock_o = '0;
`endif

  assign gnt_o       = gnt_q;
  assign busy_o      = (state_q != IDLE);
  assign upd_valid_o = upd_valid_q;
  assign upd_ch_o    = upd_ch_q;
  assign upd_rate_o  = upd_rate_q;

endmodule

// File: tb/tb_dll_loop_ctrl.sv
// Self-checking bench for dll_loop_ctrl against an arithmetic reference model
// (rates as longint, floor division for the loop gain, explicit clamping).
module tb_dll_loop_ctrl;
  localparam int NCH = 4, PW = 29, SHIFT = 4, RATEW = 32, LOCK_THR = 16, LOCK_CNT = 8;
  localparam int CW = $clog2(NCH);

  logic clk, rst;
  logic [NCH-1:0] req, chClr, gnt, lock;
  logic [NCH*PW-1:0] pE, pL;
  logic busy, updValid;
  logic [CW-1:0] updCh;
  logic signed [RATEW-1:0] updRate;

  int nCompared = 0, nMismatched = 0;
  longint mRate [NCH];
  int mCnt [NCH];
  int mLast;

  dll_loop_ctrl #(.NCH(NCH), .PW(PW), .SHIFT(SHIFT), .RATEW(RATEW),
                  .LOCK_THR(LOCK_THR), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .p_e_i(pE), .p_l_i(pL), .ch_clr_i(chClr),
    .gnt_o(gnt), .busy_o(busy), .upd_valid_o(updValid), .upd_ch_o(updCh),
    .upd_rate_o(updRate), .lock_o(lock));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint floorShift(input longint e);
    longint d;
    d = longint'(1) << SHIFT;
    if (e >= 0) return e / d;
    return -((-e + d - 1) / d);
  endfunction

  task automatic modelUpdate(input int ch, input longint pe, input longint pl, input bit clr,
                             output logic signed [RATEW-1:0] expRate);
    longint e, r, maxR, minR;
    maxR = (longint'(1) << (RATEW-1)) - 1;
    minR = -(longint'(1) << (RATEW-1));
    e = pe - pl;
    r = mRate[ch] + floorShift(e);
    if (r > maxR) r = maxR;
    if (r < minR) r = minR;
    if (clr) begin
      mRate[ch] = 0;
      mCnt[ch] = 0;
    end else begin
      mRate[ch] = r;
      if (e <= LOCK_THR && e >= -LOCK_THR) mCnt[ch] = (mCnt[ch] < LOCK_CNT) ? mCnt[ch] + 1 : LOCK_CNT;
      else mCnt[ch] = 0;
    end
    expRate = RATEW'(mRate[ch]);
  endtask

  function automatic logic [NCH-1:0] expLock();
    logic [NCH-1:0] v;
    v = '0;
`ifdef DLL_CTRL_LOCK_EN
    for (int i = 0; i < NCH; i++) v[i] = (mCnt[i] == LOCK_CNT);
`endif
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mRate[i] = 0;
      mCnt[i] = 0;
    end
    mLast = NCH - 1;
  endtask

  task automatic clearPulse(input int ch);
    @(negedge clk);
    chClr = NCH'(1) << ch;
    @(negedge clk);
    chClr = '0;
    mRate[ch] = 0;
    mCnt[ch] = 0;
  endtask

  // Drives one request through a full grant/update cycle and returns what was observed.
  task automatic runUpdate(input int ch, input longint pe, input longint pl, input bit clr,
                           output bit gotGnt, output int gntLat, output logic [NCH-1:0] gntSeen,
                           output logic [NCH-1:0] gntAfter, output logic earlyV,
                           output logic updV, output logic [CW-1:0] updC,
                           output logic signed [RATEW-1:0] updR, output logic [NCH-1:0] lockSeen);
    gotGnt = 0; gntLat = -1; gntSeen = '0; gntAfter = '0; earlyV = 0;
    updV = 0; updC = '0; updR = '0; lockSeen = '0;
    @(negedge clk);
    req = NCH'(1) << ch;
    pE[ch*PW +: PW] = PW'(pe);
    pL[ch*PW +: PW] = PW'(pl);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (gnt !== '0) begin
        gotGnt = 1;
        gntLat = c;
        break;
      end
    end
    gntSeen = gnt;
    @(negedge clk);
    req = '0;
    if (!gotGnt) return;
    @(posedge clk); #1;
    gntAfter = gnt;
    earlyV = updValid;
    @(negedge clk);
    chClr = clr ? (NCH'(1) << ch) : '0;
    @(posedge clk); #1;
    updV = updValid; updC = updCh; updR = updRate; lockSeen = lock;
    @(negedge clk);
    chClr = '0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '1; chClr = '0; pE = '0; pL = '0;
    repeat (2) @(posedge clk);
    #1;
    nCompared++; if (gnt !== '0) begin nMismatched++; $display("[TB] FAIL reset_gnt: got %b expected 0", gnt); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nCompared++; if (updValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_updv: got %b expected 0", updValid); end
    nCompared++; if (updCh !== '0) begin nMismatched++; $display("[TB] FAIL reset_updch: got %0d expected 0", updCh); end
    nCompared++; if (updRate !== '0) begin nMismatched++; $display("[TB] FAIL reset_rate: got %0d expected 0", updRate); end
    nCompared++; if (lock !== '0) begin nMismatched++; $display("[TB] FAIL reset_lock: got %b expected 0", lock); end
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    modelReset();
  endtask

  task automatic test_basic();
    bit g; int lat; logic [NCH-1:0] gs, ga, lk; logic ev, uv; logic [CW-1:0] uc;
    logic signed [RATEW-1:0] ur, er;
    runUpdate(1, 1000, 200, 0, g, lat, gs, ga, ev, uv, uc, ur, lk);
    modelUpdate(1, 1000, 200, 0, er);
    mLast = 1;
    nCompared++; if (g !== 1'b1 || lat !== 0) begin nMismatched++; $display("[TB] FAIL basic_gnt_latency: got %0d expected 0", lat); end
    nCompared++; if (gs !== 4'b0010) begin nMismatched++; $display("[TB] FAIL basic_gnt: got %b expected 0010", gs); end
    nCompared++; if (ga !== '0) begin nMismatched++; $display("[TB] FAIL basic_gnt_pulse: got %b expected 0", ga); end
    nCompared++; if (ev !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_early_valid: got %b expected 0", ev); end
    nCompared++; if (uv !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_updv: got %b expected 1", uv); end
    nCompared++; if (uc !== CW'(1)) begin nMismatched++; $display("[TB] FAIL basic_updch: got %0d expected 1", uc); end
    nCompared++; if (ur !== er) begin nMismatched++; $display("[TB] FAIL basic_rate: got %0d expected %0d", ur, er); end
  endtask

  task automatic test_negative();
    bit g; int lat; logic [NCH-1:0] gs, ga, lk; logic ev, uv; logic [CW-1:0] uc;
    logic signed [RATEW-1:0] ur, er;
    for (int n = 0; n < 2; n++) begin
      runUpdate(0, 0, 100, 0, g, lat, gs, ga, ev, uv, uc, ur, lk);
      modelUpdate(0, 0, 100, 0, er);
      mLast = 0;
      nCompared++; if (uv !== 1'b1 || uc !== CW'(0)) begin nMismatched++; $display("[TB] FAIL neg_upd%0d: got v=%b ch=%0d expected v=1 ch=0", n, uv, uc); end
      nCompared++; if (ur !== er) begin nMismatched++; $display("[TB] FAIL neg_rate%0d: got %0d expected %0d", n, ur, er); end
    end
  endtask

  task automatic test_clear();
    bit g; int lat; logic [NCH-1:0] gs, ga, lk; logic ev, uv; logic [CW-1:0] uc;
    logic signed [RATEW-1:0] ur, er;
    runUpdate(3, 5000, 100, 0, g, lat, gs, ga, ev, uv, uc, ur, lk);
    modelUpdate(3, 5000, 100, 0, er);
    nCompared++; if (ur !== er) begin nMismatched++; $display("[TB] FAIL clr_pre_rate: got %0d expected %0d", ur, er); end
    runUpdate(3, 5000, 100, 1, g, lat, gs, ga, ev, uv, uc, ur, lk);
    modelUpdate(3, 5000, 100, 1, er);
    nCompared++; if (uv !== 1'b1) begin nMismatched++; $display("[TB] FAIL clr_updv: got %b expected 1", uv); end
    nCompared++; if (ur !== er) begin nMismatched++; $display("[TB] FAIL clr_rate: got %0d expected %0d", ur, er); end
    runUpdate(3, 300, 100, 0, g, lat, gs, ga, ev, uv, uc, ur, lk);
    modelUpdate(3, 300, 100, 0, er);
    mLast = 3;
    nCompared++; if (ur !== er) begin nMismatched++; $display("[TB] FAIL clr_post_rate: got %0d expected %0d", ur, er); end
  endtask

  task automatic test_saturation();
    bit g; int lat; logic [NCH-1:0] gs, ga, lk; logic ev, uv; logic [CW-1:0] uc;
    logic signed [RATEW-1:0] ur, er;
    longint pmax;
    pmax = (longint'(1) << PW) - 1;
    clearPulse(2);
    for (int n = 0; n < 67; n++) begin
      runUpdate(2, pmax, 0, 0, g, lat, gs, ga, ev, uv, uc, ur, lk);
      modelUpdate(2, pmax, 0, 0, er);
      nCompared++; if (uv !== 1'b1 || ur !== er) begin nMismatched++; $display("[TB] FAIL sat_rate%0d: got %0d expected %0d", n, ur, er); end
    end
    mLast = 2;
  endtask

  task automatic test_reset_in_disc();
    int waited;
    @(negedge clk);
    req = 4'b0100;
    pE[2*PW +: PW] = PW'(900);
    pL[2*PW +: PW] = PW'(100);
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (gnt === '0 && waited < 8);
    nCompared++; if (gnt !== 4'b0100) begin nMismatched++; $display("[TB] FAIL rst_disc_gnt: got %b expected 0100", gnt); end
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    nCompared++; if (busy !== 1'b0 || gnt !== '0 || updValid !== 1'b0 || updCh !== '0 || updRate !== '0 || lock !== '0) begin
      nMismatched++; $display("[TB] FAIL rst_disc_outputs: got busy=%b gnt=%b v=%b ch=%0d rate=%0d lock=%b expected all 0", busy, gnt, updValid, updCh, updRate, lock);
    end
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    waited = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (updValid !== 1'b0) waited++;
    end
    nCompared++; if (waited !== 0) begin nMismatched++; $display("[TB] FAIL rst_disc_no_upd: got %0d pulses expected 0", waited); end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int grants, lastCyc, lowRun, maxLow, expCh, popped;
    logic signed [RATEW-1:0] er;
    grants = 0; lastCyc = -1; lowRun = 0; maxLow = 0;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      pE[i*PW +: PW] = PW'(300 + 16*i);
      pL[i*PW +: PW] = PW'(100);
    end
    req = '1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) lowRun++; else lowRun = 0;
      if (lowRun > maxLow) maxLow = lowRun;
      if (gnt !== '0) begin
        expCh = (mLast + 1) % NCH;
        nCompared++; if (gnt !== (NCH'(1) << expCh)) begin nMismatched++; $display("[TB] FAIL b2b_order%0d: got %b expected ch %0d", grants, gnt, expCh); end
        if (lastCyc >= 0) begin
          nCompared++; if (cyc - lastCyc !== 3) begin nMismatched++; $display("[TB] FAIL b2b_spacing%0d: got %0d expected 3", grants, cyc - lastCyc); end
        end
        q.push_back(expCh);
        mLast = expCh;
        lastCyc = cyc;
        grants++;
      end
      if (updValid === 1'b1) begin
        popped = (q.size() > 0) ? q.pop_front() : -1;
        if (popped >= 0) modelUpdate(popped, 300 + 16*popped, 100, 0, er);
        nCompared++; if (popped < 0 || updCh !== CW'(popped) || updRate !== er) begin nMismatched++; $display("[TB] FAIL b2b_upd: got ch=%0d rate=%0d expected ch=%0d rate=%0d", updCh, updRate, popped, er); end
      end
      @(negedge clk);
      req = (cyc == 14) ? '0 : ~gnt;
    end
    nCompared++; if (grants !== 5 || q.size() !== 0) begin nMismatched++; $display("[TB] FAIL b2b_count: got %0d grants expected 5", grants); end
    nCompared++; if (maxLow > 1) begin nMismatched++; $display("[TB] FAIL b2b_busy_gap: got %0d expected <=1", maxLow); end
  endtask

  task automatic test_lock();
    bit g; int lat; logic [NCH-1:0] gs, ga, lk; logic ev, uv; logic [CW-1:0] uc;
    logic signed [RATEW-1:0] ur, er;
    clearPulse(0);
    for (int n = 0; n < 9; n++) begin
      runUpdate(0, (n == 8) ? 140 : 110, 100, 0, g, lat, gs, ga, ev, uv, uc, ur, lk);
      modelUpdate(0, (n == 8) ? 140 : 110, 100, 0, er);
      nCompared++; if (lk !== expLock()) begin nMismatched++; $display("[TB] FAIL lock%0d: got %b expected %b", n, lk, expLock()); end
      nCompared++; if (ur !== er) begin nMismatched++; $display("[TB] FAIL lock_rate%0d: got %0d expected %0d", n, ur, er); end
    end
    mLast = 0;
  endtask

  task automatic test_random();
    bit g; int lat; logic [NCH-1:0] gs, ga, lk; logic ev, uv; logic [CW-1:0] uc;
    logic signed [RATEW-1:0] ur, er;
    int ch; longint pe, pl; bit clr;
    for (int n = 0; n < 30; n++) begin
      ch = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 2) == 0) begin
        pl = $urandom_range(100, 1000);
        pe = pl + $urandom_range(0, 40) - 20;
      end else begin
        pe = longint'($urandom) & ((longint'(1) << PW) - 1);
        pl = longint'($urandom) & ((longint'(1) << PW) - 1);
      end
      clr = ($urandom_range(0, 7) == 0);
      runUpdate(ch, pe, pl, clr, g, lat, gs, ga, ev, uv, uc, ur, lk);
      modelUpdate(ch, pe, pl, clr, er);
      mLast = ch;
      nCompared++; if (gs !== (NCH'(1) << ch) || uv !== 1'b1 || uc !== CW'(ch)) begin nMismatched++; $display("[TB] FAIL rand_ctrl%0d: got gnt=%b v=%b ch=%0d expected ch %0d", n, gs, uv, uc, ch); end
      nCompared++; if (ur !== er) begin nMismatched++; $display("[TB] FAIL rand_rate%0d: got %0d expected %0d", n, ur, er); end
      nCompared++; if (lk !== expLock()) begin nMismatched++; $display("[TB] FAIL rand_lock%0d: got %b expected %b", n, lk, expLock()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_clear();
    test_saturation();
    test_lock();
    test_reset_in_disc();
    test_back_to_back();
    test_random();
    applyReset();
    test_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
